// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_fa.sv
// Single-bit full adder used as the serial arithmetic slice.
module serial_fa
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// LSB-first serial adder/subtractor taking WIDTH clocks per operation.
// Optional signed overflow output is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] s_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             sum_s;
  logic             carry_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_r;
`endif

  serial_fa u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (carry_s)
  );

  assign last_s = (cnt_r == CW'(WIDTH - 1));

  // Next-state and datapath strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifters, carry, bit counter and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      if (load_s) begin
        // Subtraction is A + ~B + 1: invert B and seed the carry with 1
        a_r     <= a;
        b_r     <= (sub == MODE_SUB) ? ~b : b;
        carry_r <= sub;
        cnt_r   <= '0;
        s_r     <= '0;
        busy_r  <= 1'b1;
      end else if (step_s) begin
        s_r     <= {sum_s, s_r[WIDTH-1:1]};
        a_r     <= {1'b0, a_r[WIDTH-1:1]};
        b_r     <= {1'b0, b_r[WIDTH-1:1]};
        carry_r <= carry_s;
        cnt_r   <= cnt_r + CW'(1);
        if (last_s) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          cout_r <= carry_s;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_r  <= carry_r ^ carry_s;
`endif
        end else begin
          busy_r <= 1'b1;
        end
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign s    = s_r;
  assign cout = cout_r;
  assign busy = busy_r;
  assign done = done_r;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=8 instance checked every cycle
// against a transaction-level arithmetic model, plus literal directed vectors.
module tb_serial_addsub;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      start_v, sub_v;
  logic [1:0][7:0] a_v, b_v;
  logic [3:0]      s4;
  logic [7:0]      s8;
  logic [1:0]      cout_v, busy_v, done_v;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic [1:0]      ovf_v, m_ovf, p_ovf;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .s(s4), .cout(cout_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf_v[0])
`endif
  );

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1]), .b(b_v[1]), .s(s8), .cout(cout_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
`ifdef SERIAL_ADDSUB_OVF_EN
    , .ovf(ovf_v[1])
`endif
  );

  function automatic int wid(int k);
    return (k == 0) ? 4 : 8;
  endfunction

  // Arithmetic reference: returns {ovf, cout, result[7:0]} for a w-bit operation
  function automatic logic [9:0] ref_op(int w, logic sb, logic [7:0] x, logic [7:0] y);
    longint mask, xa, ya, r;
    logic   c, o, sx, sy, sr;
    mask = (longint'(1) << w) - 1;
    xa   = longint'(x) & mask;
    ya   = longint'(y) & mask;
    if (sb) begin
      r = xa - ya;
      c = (xa >= ya);
    end else begin
      r = xa + ya;
      c = (r > mask);
    end
    r  = r & mask;
    sx = xa[w-1];
    sy = ya[w-1];
    sr = r[w-1];
    o  = sb ? ((sx != sy) && (sr != sx)) : ((sx == sy) && (sr != sx));
    return {o, c, r[7:0]};
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[w%0d] t=%0t got %0h expected %0h", nm, wid(k), $time, act, exp);
  endtask

  // Transaction model: an accepted request finishes WIDTH clocks later
  logic [1:0]      m_busy, m_done, m_cout, p_cout;
  logic [1:0][7:0] m_s, p_s;
  logic [1:0][9:0] r_now;
  int              m_left [2];

  always_comb begin
    for (int k = 0; k < 2; k++) r_now[k] = ref_op(wid(k), sub_v[k], a_v[k], b_v[k]);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0; m_done <= '0; m_cout <= '0; m_s <= '0;
      p_s <= '0; p_cout <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      m_ovf <= '0; p_ovf <= '0;
`endif
      for (int k = 0; k < 2; k++) m_left[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (start_v[k]) begin
            m_busy[k] <= 1'b1;
            m_left[k] <= wid(k);
            m_s[k]    <= 8'h00;
            p_s[k]    <= r_now[k][7:0];
            p_cout[k] <= r_now[k][8];
`ifdef SERIAL_ADDSUB_OVF_EN
            p_ovf[k]  <= r_now[k][9];
`endif
          end
        end else begin
          m_left[k] <= m_left[k] - 1;
          if (m_left[k] == 1) begin
            m_busy[k] <= 1'b0;
            m_done[k] <= 1'b1;
            m_s[k]    <= p_s[k];
            m_cout[k] <= p_cout[k];
`ifdef SERIAL_ADDSUB_OVF_EN
            m_ovf[k]  <= p_ovf[k];
`endif
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("busy", k, 32'(busy_v[k]), 32'(m_busy[k]));
      chk("done", k, 32'(done_v[k]), 32'(m_done[k]));
      if (!m_busy[k]) begin
        chk("s", k, (k == 0) ? 32'(s4) : 32'(s8), 32'(m_s[k]));
        chk("cout", k, 32'(cout_v[k]), 32'(m_cout[k]));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("ovf", k, 32'(ovf_v[k]), 32'(m_ovf[k]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one request, then scramble the operand inputs
  task automatic go(int k, logic sb, logic [7:0] x, logic [7:0] y);
    start_v[k] = 1'b1; sub_v[k] = sb; a_v[k] = x; b_v[k] = y;
    tick();
    start_v[k] = 1'b0; sub_v[k] = ~sb; a_v[k] = ~x; b_v[k] = y ^ 8'h5A;
  endtask

  task automatic wait_done(int k, output int cyc);
    cyc = 0;
    while (!done_v[k] && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("done_seen", k, 32'(done_v[k]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pulses, first, last;
    rst_n = 1'b0; start_v = '0; sub_v = '0; a_v = '0; b_v = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    chk("pin_5p3", 0, 32'(ref_op(4, 1'b0, 8'd5, 8'd3)), 32'h208);
    chk("pin_9p9", 0, 32'(ref_op(4, 1'b0, 8'd9, 8'd9)), 32'h302);
    chk("pin_3m5", 0, 32'(ref_op(4, 1'b1, 8'd3, 8'd5)), 32'h00E);
    chk("pin_10m20", 1, 32'(ref_op(8, 1'b1, 8'h10, 8'h20)), 32'h0F0);

    // 4-bit: 5+3, then back-to-back 9+9 and 3-5 issued in the done cycle
    go(0, 1'b0, 8'd5, 8'd3);
    wait_done(0, cyc);
    chk("lat_5p3", 0, 32'(cyc), 32'd4);
    chk("s_5p3", 0, 32'(s4), 32'd8);
    chk("c_5p3", 0, 32'(cout_v[0]), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("v_5p3", 0, 32'(ovf_v[0]), 32'd1);
`endif
    go(0, 1'b0, 8'd9, 8'd9);
    wait_done(0, cyc);
    chk("lat_9p9", 0, 32'(cyc), 32'd4);
    chk("s_9p9", 0, 32'(s4), 32'd2);
    chk("c_9p9", 0, 32'(cout_v[0]), 32'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("v_9p9", 0, 32'(ovf_v[0]), 32'd1);
`endif
    go(0, 1'b1, 8'd3, 8'd5);
    wait_done(0, cyc);
    chk("lat_3m5", 0, 32'(cyc), 32'd4);
    chk("s_3m5", 0, 32'(s4), 32'd14);
    chk("c_3m5", 0, 32'(cout_v[0]), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("v_3m5", 0, 32'(ovf_v[0]), 32'd0);
`endif

    // 8-bit: start held high for 20 cycles, done every 9 cycles
    start_v[1] = 1'b1; sub_v[1] = 1'b0; a_v[1] = 8'hFF; b_v[1] = 8'h01;
    pulses = 0; first = 0; last = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_v[1]) begin
        pulses++;
        chk("s_ff01", 1, 32'(s8), 32'h00);
        chk("c_ff01", 1, 32'(cout_v[1]), 32'd1);
        if (first == 0) first = i;
        else chk("gap", 1, 32'(i - last), 32'd9);
        last = i;
      end
    end
    chk("pulses", 1, 32'(pulses), 32'd2);
    chk("first_done", 1, 32'(first), 32'd9);
    start_v[1] = 1'b0;
    wait_done(1, cyc);

    // 8-bit: reset mid-operation, then 0x10 - 0x20
    go(1, 1'b0, 8'h12, 8'h34);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 1, 32'(busy_v[1]), 32'd0);
    chk("rst_s", 1, 32'(s8), 32'd0);
    chk("rst_done", 1, 32'(done_v[1]), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    go(1, 1'b1, 8'h10, 8'h20);
    wait_done(1, cyc);
    chk("lat_10m20", 1, 32'(cyc), 32'd8);
    chk("s_10m20", 1, 32'(s8), 32'hF0);
    chk("c_10m20", 1, 32'(cout_v[1]), 32'd0);

    // Random operands in both modes; inputs churn and start toggles while busy
    for (int n = 0; n < 1000; n++) begin
      start_v = 2'b11;
      sub_v   = {n[0], n[1]};
      a_v[0] = 8'($urandom); b_v[0] = 8'($urandom);
      a_v[1] = 8'($urandom); b_v[1] = 8'($urandom);
      tick();
      repeat (8) begin
        start_v = 2'($urandom);
        sub_v   = 2'($urandom);
        a_v[0] = 8'($urandom); b_v[0] = 8'($urandom);
        a_v[1] = 8'($urandom); b_v[1] = 8'($urandom);
        tick();
      end
    end
    start_v = '0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
